// File: rtl/bullet_fire_arbiter_if.sv
// bullet_fire_arbiter_if: tank-controller / bullet-engine bus around the fire arbiter
//   game_en        game running; low blocks new grants
//   fire_req[1:0]  one-cycle fire pulses from tank 0 / tank 1
//   x/y/orient     per-tank position (10b x, 9b y) and orientation (00 up, 01 down, 10 left, 11 right)
//   bullet_done    engine pulse: bullet hit something or left the screen
//   fire_ack[1:0]  one-cycle grant pulse per tank
//   bullet_start   one-cycle launch pulse to the engine
//   bullet_owner   granted tank; bullet_x/y/orient are its latched launch values
//   busy           arbiter not idle
//   timeout_err    one-cycle pulse on a forced flight release
// slave = arbiter side, master = tanks/engine side
interface bullet_fire_arbiter_if;
    logic       game_en;
    logic [1:0] fire_req;
    logic [9:0] x_tank0;
    logic [8:0] y_tank0;
    logic [9:0] x_tank1;
    logic [8:0] y_tank1;
    logic [1:0] orient0;
    logic [1:0] orient1;
    logic       bullet_done;
    logic [1:0] fire_ack;
    logic       bullet_start;
    logic       bullet_owner;
    logic [9:0] bullet_x;
    logic [8:0] bullet_y;
    logic [1:0] bullet_orient;
    logic       busy;
    logic       timeout_err;
    modport slave (
        input  game_en, fire_req, x_tank0, y_tank0, x_tank1, y_tank1, orient0, orient1, bullet_done,
        output fire_ack, bullet_start, bullet_owner, bullet_x, bullet_y, bullet_orient, busy, timeout_err
    );
    modport master (
        output game_en, fire_req, x_tank0, y_tank0, x_tank1, y_tank1, orient0, orient1, bullet_done,
        input  fire_ack, bullet_start, bullet_owner, bullet_x, bullet_y, bullet_orient, busy, timeout_err
    );
endinterface

// File: rtl/bullet_fire_arbiter.sv
// bullet_fire_arbiter: shares one bullet engine between two tanks with pending capture, grant, flight timeout and cooldown
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    bullet_fire_arbiter_if.slave (fire requests and tank positions in; grant, launch data and status out)
//   Build option FIXED_PRIO_EN: tank 0 always wins contention; default build is round-robin.
module bullet_fire_arbiter #(
    parameter int COOLDOWN_CNT = 12000000,
    parameter int FLIGHT_TMO   = 50000000,
    parameter int CNT_W        = 28
) (
    input logic clk,
    input logic reset,
    bullet_fire_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, FLIGHT, COOLDOWN} state_t;
    localparam logic [CNT_W-1:0] CD  = CNT_W'(COOLDOWN_CNT);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(FLIGHT_TMO);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    state_t           state;
    logic [1:0]       pending;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       eff;
    logic [1:0]       grant;
    logic             win;
    logic             expired;
`ifndef FIXED_PRIO_EN
    logic             last_owner;
`endif
    always_comb begin
        eff = pending | bus.fire_req;
`ifdef FIXED_PRIO_EN
        win = ~eff[0];
`else
        win = (eff == 2'b11) ? ~last_owner : eff[1];
`endif
        grant = (state == IDLE && bus.game_en && eff != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
        // counter reaching 0 this cycle (saturated 0 also counts)
        expired = cnt <= ONE;
    end
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            pending           <= 2'b00;
            cnt               <= '0;
            bus.fire_ack      <= 2'b00;
            bus.bullet_start  <= 1'b0;
            bus.bullet_owner  <= 1'b0;
            bus.bullet_x      <= '0;
            bus.bullet_y      <= '0;
            bus.bullet_orient <= '0;
            bus.timeout_err   <= 1'b0;
`ifndef FIXED_PRIO_EN
            last_owner        <= 1'b1;
`endif
        end else begin
            bus.fire_ack     <= grant;
            bus.bullet_start <= state == LAUNCH;
            bus.timeout_err  <= 1'b0;
            // a grant consumes the pending bit, but a fresh pulse on top of an already-pending bit survives
            pending <= bus.game_en ? ((pending & ~grant) | (bus.fire_req & ~(grant & ~pending))) : 2'b00;
            case (state)
                IDLE: if (grant != 2'b00) begin
                    state             <= LAUNCH;
                    bus.bullet_owner  <= win;
                    bus.bullet_x      <= win ? bus.x_tank1 : bus.x_tank0;
                    bus.bullet_y      <= win ? bus.y_tank1 : bus.y_tank0;
                    bus.bullet_orient <= win ? bus.orient1 : bus.orient0;
`ifndef FIXED_PRIO_EN
                    last_owner        <= win;
`endif
                end
                LAUNCH: begin
                    state <= FLIGHT;
                    cnt   <= TMO;
                end
                FLIGHT: if (bus.bullet_done || expired) begin
                    bus.timeout_err <= ~bus.bullet_done;
                    state           <= (CD == '0) ? IDLE : COOLDOWN;
                    cnt             <= CD;
                end else begin
                    cnt <= cnt - ONE;
                end
                COOLDOWN: if (cnt == '0) state <= IDLE;
                          else cnt <= cnt - ONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bullet_fire_arbiter.sv
// tb_bullet_fire_arbiter: vector table, directed corner sequences and random traffic against a stage/age reference model
module tb_bullet_fire_arbiter;
    localparam int COOL = 4;
    localparam int TMO  = 20;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    bullet_fire_arbiter_if bus();
    bullet_fire_arbiter #(.COOLDOWN_CNT(COOL), .FLIGHT_TMO(TMO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    // reference model: stage 0 idle, 1 launch, 2 flight, 3 cooldown; age = cycles already spent in stage
    int m_stage, m_age, m_last;
    logic [1:0] m_pend;
    logic [1:0] e_ack;
    logic e_start, e_owner, e_busy, e_tmo;
    logic [9:0] e_x;
    logic [8:0] e_y;
    logic [1:0] e_or;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", n, a, e, $time);
        end
    endtask
    task automatic model_reset();
        m_stage = 0; m_age = 0; m_last = 1; m_pend = 2'b00;
        e_ack = 2'b00; e_start = 0; e_owner = 0; e_busy = 0; e_tmo = 0;
        e_x = '0; e_y = '0; e_or = '0;
    endtask
    task automatic model_step();
        logic [1:0] eff;
        int w, st;
        st = m_stage;
        w = -1;
        e_ack = 2'b00; e_start = 0; e_tmo = 0;
        eff = m_pend | bus.fire_req;
        if (st == 0 && bus.game_en && eff != 2'b00) begin
`ifdef FIXED_PRIO_EN
            w = eff[0] ? 0 : 1;
`else
            w = (eff == 2'b11) ? (m_last == 1 ? 0 : 1) : (eff[1] ? 1 : 0);
`endif
            e_ack[w] = 1'b1;
            e_owner = (w == 1);
            e_x = w == 1 ? bus.x_tank1 : bus.x_tank0;
            e_y = w == 1 ? bus.y_tank1 : bus.y_tank0;
            e_or = w == 1 ? bus.orient1 : bus.orient0;
            m_last = w;
            m_stage = 1;
        end else if (st == 1) begin
            e_start = 1; m_stage = 2; m_age = 0;
        end else if (st == 2) begin
            if (bus.bullet_done || m_age + 1 >= TMO) begin
                e_tmo = !bus.bullet_done;
                m_stage = COOL == 0 ? 0 : 3;
                m_age = 0;
            end else m_age++;
        end else if (st == 3) begin
            if (m_age == COOL) m_stage = 0;
            else m_age++;
        end
        for (int i = 0; i < 2; i++) begin
            if (!bus.game_en) m_pend[i] = 1'b0;
            else if (w == i) m_pend[i] = m_pend[i] & bus.fire_req[i];
            else m_pend[i] = m_pend[i] | bus.fire_req[i];
        end
        e_busy = m_stage != 0;
    endtask
    task automatic compare_all();
        chk("fire_ack", bus.fire_ack, e_ack);
        chk("bullet_start", bus.bullet_start, e_start);
        chk("bullet_owner", bus.bullet_owner, e_owner);
        chk("bullet_x", bus.bullet_x, e_x);
        chk("bullet_y", bus.bullet_y, e_y);
        chk("bullet_orient", bus.bullet_orient, e_or);
        chk("busy", bus.busy, e_busy);
        chk("timeout_err", bus.timeout_err, e_tmo);
    endtask
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask
    task automatic wait_idle(input string n);
        int k;
        k = 0;
        while (bus.busy && k < 40) begin
            tick();
            k++;
        end
        chk(n, bus.busy, 0);
    endtask
    typedef struct {
        logic [1:0] fire;
        logic       done;
        logic [1:0] ack;
        logic       start;
        logic       busy;
        logic       owner;
    } vec_t;
    vec_t tbl[18];
    initial begin
        int k;
        tbl[0]  = '{2'b01, 0, 2'b01, 0, 1, 0};
        tbl[1]  = '{2'b00, 0, 2'b00, 1, 1, 0};
        tbl[2]  = '{2'b00, 1, 2'b00, 0, 1, 0};
        for (int i = 3; i <= 6; i++) tbl[i] = '{2'b00, 0, 2'b00, 0, 1, 0};
        tbl[7]  = '{2'b00, 0, 2'b00, 0, 0, 0};
        tbl[8]  = '{2'b11, 0, 2'b10, 0, 1, 1};
        tbl[9]  = '{2'b00, 0, 2'b00, 1, 1, 1};
        tbl[10] = '{2'b00, 1, 2'b00, 0, 1, 1};
        for (int i = 11; i <= 14; i++) tbl[i] = '{2'b00, 0, 2'b00, 0, 1, 1};
        tbl[15] = '{2'b00, 0, 2'b00, 0, 0, 1};
        tbl[16] = '{2'b00, 0, 2'b01, 0, 1, 0};
        tbl[17] = '{2'b00, 0, 2'b00, 1, 1, 0};
        bus.game_en = 1'b1; bus.fire_req = 2'b00; bus.bullet_done = 1'b0;
        bus.x_tank0 = 10'd100; bus.y_tank0 = 9'd200; bus.orient0 = 2'b11;
        bus.x_tank1 = 10'd300; bus.y_tank1 = 9'd150; bus.orient1 = 2'b10;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset busy", bus.busy, 0);
        chk("reset ack", bus.fire_ack, 0);
        chk("reset owner", bus.bullet_owner, 0);
        chk("reset x", bus.bullet_x, 0);
        // table: single request, round-robin contention, pending served without a new pulse
        for (int i = 0; i < 18; i++) begin
            bus.fire_req = tbl[i].fire;
            bus.bullet_done = tbl[i].done;
            tick();
            chk($sformatf("tbl%0d ack", i), bus.fire_ack, tbl[i].ack);
            chk($sformatf("tbl%0d start", i), bus.bullet_start, tbl[i].start);
            chk($sformatf("tbl%0d busy", i), bus.busy, tbl[i].busy);
            chk($sformatf("tbl%0d owner", i), bus.bullet_owner, tbl[i].owner);
            if (i == 0) begin
                chk("single x", bus.bullet_x, 100);
                chk("single y", bus.bullet_y, 200);
                chk("single orient", bus.bullet_orient, 3);
            end
        end
        bus.fire_req = 2'b00; bus.bullet_done = 1'b0;
        // reset in the middle of a flight
        tick();
        #3;
        reset = 1'b1;
        #1;
        chk("midrst busy", bus.busy, 0);
        chk("midrst owner", bus.bullet_owner, 0);
        chk("midrst x", bus.bullet_x, 0);
        chk("midrst start", bus.bullet_start, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.fire_req = 2'b10;
        tick();
        chk("postrst ack", bus.fire_ack, 2'b10);
        bus.fire_req = 2'b00;
        tick();
        chk("postrst start", bus.bullet_start, 1);
        // contention right after reset: tank 0 first, tank 1 later from pending
        do_reset();
        bus.fire_req = 2'b11;
        tick();
        chk("cont first ack", bus.fire_ack, 2'b01);
        bus.fire_req = 2'b00;
        tick();
        bus.bullet_done = 1'b1;
        tick();
        bus.bullet_done = 1'b0;
        k = 0;
        while (bus.fire_ack == 2'b00 && k < 12) begin
            tick();
            k++;
        end
        chk("cont second ack", bus.fire_ack, 2'b10);
        chk("cont second delay", k, COOL + 2);
        // flight timeout with no done
        tick();
        k = 0;
        while (!bus.timeout_err && k < 30) begin
            tick();
            k++;
        end
        chk("timeout cycles", k, TMO);
        chk("timeout busy", bus.busy, 1);
        wait_idle("timeout idle");
        // done on the last flight cycle suppresses the timeout
        bus.fire_req = 2'b01;
        tick();
        bus.fire_req = 2'b00;
        tick();
        repeat (TMO - 1) tick();
        bus.bullet_done = 1'b1;
        tick();
        bus.bullet_done = 1'b0;
        chk("late done tmo", bus.timeout_err, 0);
        chk("late done busy", bus.busy, 1);
        wait_idle("late done idle");
        // game_en drop while tank 1 pending and a bullet in flight
        bus.fire_req = 2'b01;
        tick();
        bus.fire_req = 2'b00;
        tick();
        tick();
        bus.fire_req = 2'b10;
        tick();
        bus.fire_req = 2'b00;
        bus.game_en = 1'b0;
        tick();
        tick();
        chk("gdrop still busy", bus.busy, 1);
        bus.bullet_done = 1'b1;
        tick();
        bus.bullet_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("gdrop no ack", bus.fire_ack, 0);
        end
        chk("gdrop idle", bus.busy, 0);
        bus.game_en = 1'b1;
        tick();
        chk("gdrop pending cleared", bus.fire_ack, 0);
        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bus.game_en = $urandom_range(0, 24) != 0;
            bus.fire_req = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0};
            bus.bullet_done = $urandom_range(0, 13) == 0;
            bus.x_tank0 = 10'($urandom); bus.y_tank0 = 9'($urandom); bus.orient0 = 2'($urandom);
            bus.x_tank1 = 10'($urandom); bus.y_tank1 = 9'($urandom); bus.orient1 = 2'($urandom);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
